// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and constants for the PWM on-time ramp sequencer.
package pwm_ramp_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DWELL = 2'd2,
        STEP  = 2'd3
    } pwm_ramp_state_t;

    // Keeps the target below the datapath's T_on_MAX = T_period - 3.
    localparam int unsigned T_ON_MAX_MARGIN = 3;

    localparam int unsigned STATUS_WIDTH     = 32;
    localparam int unsigned RAMP_BUSY        = 31;
    localparam int unsigned RAMP_AT_TARGET   = 30;
    localparam int unsigned RAMP_ABORT_SEEN  = 29;
    localparam int unsigned STATUS_DWELL_LSB = 16;
    localparam int unsigned STATUS_DWELL_W   = 8;

endpackage

// File: rtl/ramp_step_calc.sv
// One ramp step: move current toward target by at most step, never overshooting.
module ramp_step_calc #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STEP_WIDTH = 16
) (
    input  logic [WIDTH-1:0]      current,
    input  logic [WIDTH-1:0]      target,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [WIDTH-1:0]      next_value,
    output logic                  reached_flag
);

    localparam int unsigned DW = WIDTH + 1;

    logic          up;
    logic [DW-1:0] diff;
    logic [DW-1:0] step_ext;

    // Distance is formed one bit wider so neither direction can wrap.
    always_comb begin
        up           = target >= current;
        diff         = up ? (DW'(target) - DW'(current)) : (DW'(current) - DW'(target));
        step_ext     = DW'(step);
        reached_flag = (step == '0) || (diff <= step_ext);
        if (reached_flag) begin
            next_value = target;
        end else if (up) begin
            next_value = current + WIDTH'(step);
        end else begin
            next_value = current - WIDTH'(step);
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramps one PWM channel's on-time toward a commanded target, committing
// each change right after a period boundary; abort forces T_on to zero.
module pwm_ramp_sequencer
    import pwm_ramp_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned STEP_WIDTH  = 16,
    parameter int unsigned DWELL_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WIDTH-1:0]        cmd_target,
    input  logic [STEP_WIDTH-1:0]   cmd_step,
    input  logic [DWELL_WIDTH-1:0]  cmd_dwell,
    input  logic                    period_start,
    input  logic [WIDTH-1:0]        T_period,
    input  logic                    abort,
    output logic [WIDTH-1:0]        T_on_out,
    output logic                    T_on_update,
    output logic                    busy,
    output logic                    done,
    output logic [STATUS_WIDTH-1:0] status
);

    pwm_ramp_state_t         state_q, state_d;
    logic [WIDTH-1:0]        t_on_q, t_on_d;
    logic [WIDTH-1:0]        target_q, target_d;
    logic [STEP_WIDTH-1:0]   step_q, step_d;
    logic [DWELL_WIDTH-1:0]  dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_WIDTH-1:0]  cnt_dec;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    upd_q, upd_d;
    logic                    abort_seen_q, abort_seen_d;
    logic [STATUS_WIDTH-1:0] status_q, status_d;
    logic                    ready_en_q;

    logic [WIDTH-1:0]        period_limit;
    logic [WIDTH-1:0]        clamped;
    logic                    accept;
    logic [WIDTH-1:0]        calc_next;
    logic                    calc_reached;

    assign period_limit = T_period - WIDTH'(T_ON_MAX_MARGIN);
    assign clamped      = (T_period < WIDTH'(T_ON_MAX_MARGIN)) ? '0 :
                          ((cmd_target > period_limit) ? period_limit : cmd_target);

    // ready_en_q holds cmd_ready low for as long as reset is asserted.
    assign cmd_ready = ready_en_q & (state_q == IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;

    ramp_step_calc #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step_calc (
        .current      (t_on_q),
        .target       (target_q),
        .step         (step_q),
        .next_value   (calc_next),
        .reached_flag (calc_reached)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            t_on_q       <= '0;
            target_q     <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            upd_q        <= 1'b0;
            abort_seen_q <= 1'b0;
            status_q     <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_on_q       <= t_on_d;
            target_q     <= target_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            upd_q        <= upd_d;
            abort_seen_q <= abort_seen_d;
            status_q     <= status_d;
            ready_en_q   <= 1'b1;
        end
    end

    // The step is applied on the period_start edge itself; STEP is the
    // cycle in which the new value is visible and the next wait is chosen.
    always_comb begin
        state_d      = state_q;
        t_on_d       = t_on_q;
        target_d     = target_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        dwell_cnt_d  = dwell_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        upd_d        = 1'b0;
        abort_seen_d = abort_seen_q;
        cnt_dec      = '0;

        if (abort) begin
            state_d      = IDLE;
            t_on_d       = '0;
            upd_d        = (t_on_q != '0);
            busy_d       = 1'b0;
            abort_seen_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        target_d     = clamped;
                        step_d       = cmd_step;
                        dwell_d      = (cmd_dwell == '0) ? DWELL_WIDTH'(1) : cmd_dwell;
                        abort_seen_d = 1'b0;
                        if (clamped == t_on_q) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = ARMED;
                        end
                    end
                end
                ARMED, DWELL: begin
                    if (period_start) begin
                        cnt_dec     = ((state_q == ARMED) ? dwell_q : dwell_cnt_q) - DWELL_WIDTH'(1);
                        dwell_cnt_d = cnt_dec;
                        if (cnt_dec == '0) begin
                            t_on_d  = calc_next;
                            upd_d   = (calc_next != t_on_q);
                            state_d = STEP;
                            if (calc_reached) begin
                                done_d = 1'b1;
                                busy_d = 1'b0;
                            end
                        end else begin
                            state_d = DWELL;
                        end
                    end
                end
                STEP: begin
                    if (busy_q) begin
                        state_d     = DWELL;
                        dwell_cnt_d = dwell_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        status_d                                         = '0;
        status_d[RAMP_BUSY]                              = busy_d;
        status_d[RAMP_AT_TARGET]                         = (t_on_d == target_d) & ~busy_d;
        status_d[RAMP_ABORT_SEEN]                        = abort_seen_d;
        status_d[STATUS_DWELL_LSB +: STATUS_DWELL_W]     = STATUS_DWELL_W'(dwell_cnt_d);
    end

    assign T_on_out    = t_on_q;
    assign T_on_update = upd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Controller that sequences the on-time (T_on) of one PWM channel. It ramps T_on from its current value toward a commanded target in fixed steps. Every change is committed only at a PWM period boundary, so no period is ever truncated or extended. It sits between the channel's register/bus logic (command source) and the PWM datapath (T_on consumer), and supports soft start and soft stop of motors via the H-bridge path.

Parameters:
WIDTH, 32, width of timing values in 20nS units (matches T_on/T_period)
STEP_WIDTH, 16, width of the per-step increment
DWELL_WIDTH, 8, width of the periods-per-step count

Ports:
clk  input  1  system clock (50MHz)
reset  input  1  asynchronous active-low reset
cmd_valid  input  1  new ramp command present
cmd_ready  output  1  block can accept a command (high only in IDLE, with abort low)
cmd_target  input  WIDTH  target T_on
cmd_step  input  STEP_WIDTH  T_on change per step; 0 = jump straight to target
cmd_dwell  input  DWELL_WIDTH  PWM periods per step; 0 treated as 1
period_start  input  1  one-cycle pulse from PWM datapath at period reload
T_period  input  WIDTH  current channel period, used for clamping
abort  input  1  level; forces T_on to 0 immediately
T_on_out  output  WIDTH  on-time delivered to PWM datapath
T_on_update  output  1  one-cycle pulse whenever T_on_out changes
busy  output  1  ramp in progress
done  output  1  one-cycle pulse when T_on_out reaches the target
status  output  32  {busy, at_target, abort_seen, 5'b0, dwell_cnt[7:0], 16'b0}

Behaviour:
- Reset (async, reset=0): state=IDLE. T_on_out=0, T_on_update=0, busy=0, done=0, cmd_ready=0 while reset is asserted. Target=0, dwell_cnt=0, abort_seen=0.
- States: IDLE, ARMED, DWELL, STEP.
- IDLE: cmd_ready=1 when abort=0. On cmd_valid&cmd_ready the command is latched:
  - target = min(cmd_target, T_period-3). The -3 matches the datapath T_on_MAX limit; if T_period<3, target=0.
  - step and dwell are latched (dwell 0 becomes 1).
  - If target==T_on_out: done pulses next cycle and the block stays in IDLE.
  - Otherwise: busy=1, go to ARMED.
- ARMED: wait for period_start. Then dwell_cnt=dwell-1. If dwell_cnt==0 go to STEP, else go to DWELL.
- DWELL: each period_start decrements dwell_cnt. When it reaches 0, go to STEP on that same period_start.
- STEP (single cycle, entered only on the cycle after a period_start):
  - diff = |target-T_on_out|, computed at WIDTH+1 bits with no wrap.
  - If step==0 or diff<=step: T_on_out=target, done pulse, busy=0, go to IDLE.
  - Otherwise T_on_out moves by ±step toward target, dwell_cnt reloads, go to DWELL (or STEP at the next period_start if dwell==1).
  - T_on_update pulses in the same cycle T_on_out changes.
- Latency: period_start at cycle N gives a new T_on_out and T_on_update at N+1. The datapath reloads from T_on_out at the following period boundary.
- A period_start arriving while in STEP is consumed by STEP. For dwell==1, T_on changes every period.
- abort (any state, priority over everything): next cycle T_on_out=0, T_on_update=1 (only if T_on_out was non-zero), busy=0, abort_seen=1, state=IDLE. abort_seen clears on the next accepted command.
- abort together with cmd_valid: the command is not accepted (cmd_ready=0).
- cmd_valid while busy is ignored; there is no retargeting mid-ramp. Software must abort or wait for done.
- T_period changes mid-ramp: target is not re-clamped. The datapath's own T_on_MAX limit protects the output.
- at_target = (T_on_out==target) & ~busy.

Decomposition:
- Shared package / global_constants: state enum pwm_ramp_state_t (IDLE, ARMED, DWELL, STEP), T_ON_MAX_MARGIN=3, and status bit positions RAMP_BUSY=31, RAMP_AT_TARGET=30, RAMP_ABORT_SEEN=29.
- One natural sub-module: ramp_step_calc. It is combinational and takes current, target and step; it returns next_value and reached_flag with no overflow or underflow. It is reused by future velocity ramps.

Test Plan:
1. Reset with T_period=1000 -> T_on_out=0, busy=0. Command target=100, step=25, dwell=1, then period_start every 1000 cycles -> T_on_out 25, 50, 75, 100 on successive periods, each one cycle after period_start; done pulses with the 100 update; busy falls.
2. Ramp down from 100 to target=10, step=40, dwell=2 -> T_on_out 60 after 2 periods, 20 after 4, 10 after 6; never goes below 10.
3. Target=5000 with T_period=1000 -> clamped to 997. step=0 -> single jump to 997 at the first period_start; done pulses.
4. Mid-ramp abort (T_on_out=50) -> next cycle T_on_out=0, T_on_update=1, busy=0, status[29]=1. An abort asserted with cmd_valid -> command not accepted.
5. cmd_valid while busy (target=300 during a ramp to 100) -> ignored; the ramp completes at 100.
6. Command with target equal to the current T_on_out -> done pulse, no T_on_update, state stays IDLE. Assert reset mid-DWELL -> all outputs return to their reset values immediately (async).
